// File: rtl/blackboxjam_mul_acc_stream_if.sv
// Operand and sum stream bundle for the dot-product accumulator.
// master drives operands and sinks sums; slave is the accumulator side.
interface blackboxjam_mul_acc_stream_if #(
  parameter int ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [11:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/blackboxjam_mul_acc_stream.sv
// Streaming dot-product accumulator around a 1-cycle ce-gated
// 32s x 12u multiplier; emits one wrapped 32b sum per frame.
module blackboxjam_mul_acc_stream #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      cfg_num_terms,
  blackboxjam_mul_acc_stream_if.slave strm,
  output logic                  mul_ce,
  output logic [31:0]           mul_din0,
  output logic [11:0]           mul_din1,
  input  logic [ACC_W-1:0]      mul_dout,
  output logic                  busy
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t           state;
  logic             v1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [ACC_W-1:0] acc;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;

  logic             adv;
  logic             fire;
  logic             last;
  logic [CNT_W-1:0] len_cfg;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W-1:0] sum;

  // A held sum freezes the whole pipe, multiplier included.
  assign adv  = !out_valid || strm.out_ready;
  assign fire = strm.in_valid && adv;

  assign strm.in_ready  = adv;
  assign strm.out_valid = out_valid;
  assign strm.out_data  = out_data;

  assign mul_ce   = adv;
  assign mul_din0 = strm.in_a;
  assign mul_din1 = strm.in_b;

  assign len_cfg = (cfg_num_terms == '0) ?
                   CNT_W'(1) : cfg_num_terms;
  // Frame length is latched on the first term only.
  assign len_eff = (cnt == '0) ? len_cfg : len_q;
  assign cnt_nxt = cnt + CNT_W'(1);
  assign last    = (cnt_nxt == len_eff);
  assign sum     = acc + mul_dout;

  assign busy = (state != S_IDLE) || v1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      v1        <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v1 <= fire;
      if (v1) begin
        if (cnt == '0) begin
          len_q <= len_cfg;
        end
        if (last) begin
          out_data  <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= S_IDLE;
        end else begin
          acc       <= sum;
          cnt       <= cnt_nxt;
          out_valid <= 1'b0;
          state     <= S_ACCUM;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
